// File: rtl/vram_arbiter.sv
// Video RAM arbiter: one fixed video fetch slot per byte cell, every other cycle
// offered to the CPU through a req/ack handshake (issue, ack, gap).
module vram_arbiter #(
  parameter int ADDR_W    = 13,
  parameter int DATA_W    = 8,
  parameter int SLOT_LEN  = 16,
  parameter int VID_PHASE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vid_sync,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int PW = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
  localparam logic [PW-1:0] VID_PH   = PW'(VID_PHASE);
  localparam logic [PW-1:0] VID_NEXT = PW'(VID_PHASE + 1);
  localparam logic [PW-1:0] PH_ONE   = PW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_n_s;
  logic [PW-1:0]       phase_r;
  logic [PW-1:0]       phase_n_s;
  logic                vslot_s;
  logic                issue_s;
  logic                vid_lat_r;
  logic [DATA_W-1:0]   vid_data_r;
  logic                cpu_rd_lat_r;
  logic [DATA_W-1:0]   cpu_rdata_r;
  logic                cpu_ack_r;

  // Video slot detection and phase advance (vid_sync forces the slot).
  always_comb begin
    vslot_s   = 1'b0;
    phase_n_s = phase_r + PH_ONE;
    if (vid_sync) begin
      vslot_s   = 1'b1;
      phase_n_s = VID_NEXT;
    end else begin
      vslot_s   = (phase_r == VID_PH);
      phase_n_s = phase_r + PH_ONE;
    end
  end

  // CPU FSM next state; issue is also gated by reset so ram_we drops at once.
  always_comb begin
    state_n_s = state_r;
    issue_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (cpu_req && !vslot_s && reset) begin
          issue_s   = 1'b1;
          state_n_s = ACK;
        end else begin
          issue_s   = 1'b0;
          state_n_s = IDLE;
        end
      end
      ACK:     state_n_s = GAP;
      GAP:     state_n_s = IDLE;
      default: state_n_s = IDLE;
    endcase
  end

  // RAM port mux: the video slot always owns the address.
  always_comb begin
    ram_addr = cpu_addr;
    ram_we   = 1'b0;
    if (vslot_s) begin
      ram_addr = vid_addr;
      ram_we   = 1'b0;
    end else begin
      ram_addr = cpu_addr;
      ram_we   = issue_s & cpu_we;
    end
  end

  assign ram_wdata = cpu_wdata;

  // Phase counter and CPU FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_r <= '0;
      state_r <= IDLE;
    end else begin
      phase_r <= phase_n_s;
      state_r <= state_n_s;
    end
  end

  // Separate video and CPU data latches, each sampling only in its own
  // post-issue cycle so a CPU read just before the slot cannot contaminate video.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vid_lat_r    <= 1'b0;
      vid_data_r   <= '0;
      cpu_rd_lat_r <= 1'b0;
      cpu_rdata_r  <= '0;
      cpu_ack_r    <= 1'b0;
    end else begin
      vid_lat_r    <= vslot_s;
      cpu_rd_lat_r <= issue_s & ~cpu_we;
      cpu_ack_r    <= issue_s;
      if (vid_lat_r) begin
        vid_data_r <= ram_rdata;
      end else begin
        vid_data_r <= vid_data_r;
      end
      if (cpu_rd_lat_r) begin
        cpu_rdata_r <= ram_rdata;
      end else begin
        cpu_rdata_r <= cpu_rdata_r;
      end
    end
  end

  // During the ack cycle of a read the RAM output register is forwarded so the
  // data is valid alongside cpu_ack; the local copy holds it afterwards.
  always_comb begin
    cpu_rdata = cpu_rdata_r;
    if (cpu_rd_lat_r) begin
      cpu_rdata = ram_rdata;
    end else begin
      cpu_rdata = cpu_rdata_r;
    end
  end

  assign vid_data = vid_data_r;
  assign cpu_ack  = cpu_ack_r;

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the single-port 8 KB video RAM between the VGA scan-out engine and the 6502 CPU bus.
- The VGA engine fetches one byte per 16-clock character/byte cell. The arbiter reserves one fixed RAM slot per cell for that fetch and holds the fetched byte stable for the rest of the cell.
- All other cycles are granted to the CPU through a req/ack handshake.
- Sits between the CPU bus decoder, the VGA generator and the video RAM macro, which has synchronous read with 1-cycle latency.

Parameters:
ADDR_W, 13, address width of video RAM, CPU address and video address
DATA_W, 8, data width
SLOT_LEN, 16, clocks per video byte cell; must be a power of two
VID_PHASE, 0, phase within the cell at which the video read is issued

Ports:
clk  input  1  pixel clock (65 MHz)
reset  input  1  asynchronous, active-low reset (0 = in reset)
vid_sync  input  1  one-cycle pulse from the VGA generator marking phase VID_PHASE (its byte-cell counter low bits == 0)
vid_addr  input  ADDR_W  video fetch address, stable during the video slot
vid_data  output  DATA_W  registered video byte, held until the next video fetch completes
cpu_req  input  1  CPU access request; level, held until cpu_ack
cpu_we  input  1  1 = write, 0 = read; stable while cpu_req is high
cpu_addr  input  ADDR_W  CPU address; stable while cpu_req is high
cpu_wdata  input  DATA_W  CPU write data
cpu_rdata  output  DATA_W  registered CPU read data, valid when cpu_ack = 1 for a read
cpu_ack  output  1  one-cycle completion pulse
ram_addr  output  ADDR_W  RAM address (combinational mux)
ram_we  output  1  RAM write enable (combinational)
ram_wdata  output  DATA_W  RAM write data (= cpu_wdata)
ram_rdata  input  DATA_W  RAM read data, valid 1 cycle after the address cycle

Behaviour:
- Reset (reset = 0, asynchronous):
  - phase = 0, state = IDLE, vid_data = 0, cpu_rdata = 0, cpu_ack = 0, internal video/CPU latch flags = 0.
  - ram_we = 0 immediately.
  - An in-flight CPU access is abandoned with no ack; a write issued in the reset cycle is not guaranteed to have landed.
- Phase counter:
  - log2(SLOT_LEN) bits; increments mod SLOT_LEN each clock.
  - If vid_sync = 1, the current cycle is treated as phase VID_PHASE and phase is loaded with VID_PHASE+1 on the next edge. This resynchronises at any phase.
  - Without vid_sync pulses it free-runs, so the video slot still recurs every SLOT_LEN cycles.
- Video slot (vslot = (phase == VID_PHASE) | vid_sync):
  - ram_addr = vid_addr, ram_we = 0.
  - A CPU access is never issued in a vslot cycle, even with cpu_req high.
  - On the next edge, vid_lat is set. On the edge after that, vid_data <= ram_rdata, i.e. vid_data changes 2 clocks after vslot.
  - vid_data is stable from phase VID_PHASE+2 to VID_PHASE+1 of the next cell, covering the VGA sample at phase SLOT_LEN-1.
- CPU FSM states:
  - IDLE:
    - If cpu_req & ~vslot, issue: ram_addr = cpu_addr, ram_we = cpu_we, then go to ACK.
    - Otherwise ram_addr = cpu_addr, ram_we = 0.
  - ACK:
    - This state is the cycle after issue. cpu_ack is asserted registered, so it is visible during this cycle.
    - For a read, cpu_rdata <= ram_rdata on the issuing edge +1; equivalently, cpu_rdata is valid in the same cycle cpu_ack is high and holds afterwards.
    - Next state is GAP.
  - GAP: one dead cycle so the requester can drop cpu_req; no issue. Then go to IDLE.
- CPU throughput and latency:
  - Back-to-back CPU accesses occur at most one per 3 cycles.
  - Best-case ack arrives 1 cycle after req. Worst case is 2 (req arriving at vslot).
- CPU read and video fetch on the same RAM output: a CPU read issued at phase VID_PHASE-1 has its data cycle at VID_PHASE. Both are latched correctly because the latches are separate and each samples only in its own post-issue cycle.
- cpu_req dropped before issue: no access and no ack. cpu_req dropped after issue: access completes and is acked anyway.
- ram_wdata = cpu_wdata at all times; only ram_we qualifies it.

Test Plan:
- Reset mid-write: assert reset = 0 while ram_we = 1 → ram_we = 0 and cpu_ack = 0 within the same cycle; after release, phase = 0 and vid_data = 0x00.
- Video fetch: RAM[0x0123] = 0xA5, vid_addr = 0x0123, vid_sync pulse at cycle T → ram_addr = 0x0123 at T, vid_data = 0xA5 from T+2; still 0xA5 at T+15.
- CPU read outside the slot: RAM[0x1F00] = 0x3C, cpu_req at phase 5 → issue at phase 5, cpu_ack high for exactly 1 cycle at phase 6 with cpu_rdata = 0x3C.
- Collision: cpu_req write 0x77 → 0x0040 rising in the same cycle as vid_sync → the video read goes first, the CPU write is issued the next cycle (ram_we = 1 at T+1), ack at T+2; a subsequent video read of 0x0040 returns 0x77.
- Read at VID_PHASE-1: RAM[0x0010] = 0x11 (CPU), RAM[0x0020] = 0x22 (video) → cpu_rdata = 0x11 and vid_data = 0x22, no cross-contamination.
- Sustained CPU traffic with cpu_req held high for 64 cycles and no vid_sync → exactly one ack per 3 cycles except where a free-running vslot delays an issue; vid_data refreshes every 16 cycles throughout.
